fsm_ring_sequencer: RTL and testbench

// - Parametrised N-state cyclic Moore sequencer, successor to the 3-state run-stepped FSM.
// - Steps through states 0..NUM_STATES-1, forward or backward, when run is asserted.
// - Each step waits a programmable dwell count, and the current state is exported binary and one-hot.
// - Sits in control paths as a phase/slot generator: y marks one selected phase, wrap marks cycle completion.

---
 rtl/fsm_ring_pkg.sv | 16 +
 rtl/fsm_ring_dwell_cnt.sv | 24 ++
 rtl/fsm_ring_sequencer.sv | 79 +++++++
 tb/tb_fsm_ring_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fsm_ring_pkg.sv
// rtl/fsm_ring_pkg.sv - shared constants and index helpers for the ring sequencer
package fsm_ring_pkg;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_BWD = 1'b1;

  function automatic int state_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int ring_next(input int state, input logic dir, input int n);
    if (dir == DIR_FWD) return (state == n - 1) ? 0 : state + 1;
    else                return (state == 0) ? n - 1 : state - 1;
  endfunction

endpackage

// File: rtl/fsm_ring_dwell_cnt.sv
// rtl/fsm_ring_dwell_cnt.sv - per-state dwell counter; adv fires once cnt reaches dwell
module fsm_ring_dwell_cnt #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               clr,
  output logic               adv
);

  logic [DWELL_W-1:0] cnt;

  // >= lets a shrinking dwell release immediately instead of waiting for a wrap
  assign adv = run && (cnt >= dwell);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            cnt <= '0;
    else if (clr || adv)  cnt <= '0;
    else if (run)         cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/fsm_ring_sequencer.sv
// rtl/fsm_ring_sequencer.sv - N-state cyclic Moore sequencer with dwell, direction and wrap pulse
// Optional FSM_RING_ILLEGAL_RECOVERY_EN: out-of-range state returns to 0 and pulses err.
module fsm_ring_sequencer
  import fsm_ring_pkg::*;
#(
  parameter int NUM_STATES   = 3,
  parameter int DWELL_W      = 4,
  parameter int ACTIVE_STATE = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            run,
  input  logic                            dir,
  input  logic [DWELL_W-1:0]              dwell,
  output logic [state_w(NUM_STATES)-1:0]  state,
  output logic [NUM_STATES-1:0]           state_oh,
  output logic                            y,
  output logic                            wrap,
  output logic                            err
);

  localparam int SW = state_w(NUM_STATES);

  logic [SW-1:0] state_q, state_d;
  logic          wrap_q, wrap_d, err_q;
  logic          legal, adv, clr;

  assign legal = int'(state_q) < NUM_STATES;

`ifdef FSM_RING_ILLEGAL_RECOVERY_EN
  assign clr = !legal;
`else
  assign clr = 1'b0;
`endif

  fsm_ring_dwell_cnt #(.DWELL_W(DWELL_W)) u_dwell (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .dwell (dwell),
    .clr   (clr),
    .adv   (adv)
  );

  always_comb begin
    state_d = state_q;
    wrap_d  = 1'b0;
    if (clr) begin
      state_d = '0;
    end else if (legal && adv) begin
      state_d = SW'(ring_next(int'(state_q), dir, NUM_STATES));
      wrap_d  = (dir == DIR_FWD) ? (int'(state_q) == NUM_STATES - 1) : (state_q == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wrap_q  <= wrap_d;
      err_q   <= clr;
    end
  end

  // illegal indices decode to all-zero one-hot and y=0
  always_comb begin
    state_oh = '0;
    for (int i = 0; i < NUM_STATES; i++) state_oh[i] = (int'(state_q) == i);
  end

  assign state = state_q;
  assign y     = (int'(state_q) == ACTIVE_STATE);
  assign wrap  = wrap_q;
  assign err   = err_q;

endmodule

// File: tb/tb_fsm_ring_sequencer.sv
// tb/tb_fsm_ring_sequencer.sv - directed bench: legacy 3-state ring and a 5-state instance
module tb_fsm_ring_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       dir;
  logic [3:0] dwell;

  logic [1:0] s3;
  logic [2:0] oh3;
  logic       y3, wrap3, err3;
  logic [2:0] s5;
  logic [4:0] oh5;
  logic       y5, wrap5, err5;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fsm_ring_sequencer dut3 (
    .clk(clk), .reset(reset), .run(run), .dir(dir), .dwell(dwell),
    .state(s3), .state_oh(oh3), .y(y3), .wrap(wrap3), .err(err3)
  );

  fsm_ring_sequencer #(.NUM_STATES(5), .DWELL_W(4), .ACTIVE_STATE(2)) dut5 (
    .clk(clk), .reset(reset), .run(run), .dir(dir), .dwell(dwell),
    .state(s5), .state_oh(oh5), .y(y5), .wrap(wrap5), .err(err5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    run   = 1'b0;
    dir   = 1'b0;
    dwell = 4'd0;
    @(negedge clk);
    check("rst_state3", 32'(s3), 0);
    check("rst_oh3", 32'(oh3), 32'b001);
    check("rst_y3", 32'(y3), 0);
    check("rst_wrap3", 32'(wrap3), 0);
    check("rst_err3", 32'(err3), 0);
    check("rst_oh5", 32'(oh5), 32'b00001);

    // legacy ring: 0,1,2,0,1,2 with y in state 2 and wrap on return to 0
    reset = 1'b0;
    run   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("leg_state_%0d", i), 32'(s3), 32'(i % 3));
      check($sformatf("leg_y_%0d", i), 32'(y3), 32'((i % 3) == 2));
      check($sformatf("leg_wrap_%0d", i), 32'(wrap3), 32'(i == 3));
      step();
    end

    // dwell=3: four cycles per state, then a two-cycle pause mid-dwell
    do_reset();
    dwell = 4'd3;
    dir   = 1'b0;
    run   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("dw_state_%0d", i), 32'(s5), 32'((i / 4) % 5));
      step();
    end
    run = 1'b0;
    step();
    check("pause_state_a", 32'(s5), 2);
    check("pause_wrap", 32'(wrap5), 0);
    step();
    check("pause_state_b", 32'(s5), 2);
    check("pause_oh", 32'(oh5), 32'b00100);
    check("pause_y", 32'(y5), 1);
    run = 1'b1;
    step();
    check("resume_hold", 32'(s5), 2);
    step();
    check("resume_adv", 32'(s5), 3);

    // backward with wrap, then direction flipped mid-dwell
    do_reset();
    dwell = 4'd0;
    dir   = 1'b1;
    run   = 1'b1;
    check("bwd_start", 32'(s5), 0);
    step();
    check("bwd_state4", 32'(s5), 4);
    check("bwd_wrap4", 32'(wrap5), 1);
    step();
    check("bwd_state3", 32'(s5), 3);
    check("bwd_wrap3", 32'(wrap5), 0);
    step();
    check("bwd_state2", 32'(s5), 2);
    dwell = 4'd2;
    step();
    dir = 1'b0;
    step();
    check("dirflip_hold", 32'(s5), 2);
    step();
    check("dirflip_fwd", 32'(s5), 3);

    // shrinking dwell below the running count releases on the next cycle
    do_reset();
    dwell = 4'd7;
    dir   = 1'b0;
    run   = 1'b1;
    repeat (5) step();
    check("shrink_pre", 32'(s5), 0);
    dwell = 4'd2;
    step();
    check("shrink_adv", 32'(s5), 1);
    step();
    check("shrink_c1", 32'(s5), 1);
    step();
    check("shrink_c2", 32'(s5), 1);
    step();
    check("shrink_next", 32'(s5), 2);

    // asynchronous reset mid-cycle
    do_reset();
    dwell = 4'd0;
    run   = 1'b1;
    repeat (3) step();
    check("arst_pre", 32'(s5), 3);
    #2 reset = 1'b1;
    #1;
    check("arst_state", 32'(s5), 0);
    check("arst_wrap", 32'(wrap5), 0);
    check("arst_y", 32'(y5), 0);
    check("arst_oh", 32'(oh5), 32'b00001);
    @(negedge clk);
    reset = 1'b0;
    step();
    check("arst_release", 32'(s5), 1);

    // illegal state injected into the 5-state ring
    do_reset();
    dwell = 4'd0;
    run   = 1'b1;
    force dut5.state_q = 3'd6;
    #1;
    release dut5.state_q;
    check("ill_state", 32'(s5), 6);
    check("ill_oh", 32'(oh5), 0);
    check("ill_y", 32'(y5), 0);
    check("ill_err0", 32'(err5), 0);
`ifdef FSM_RING_ILLEGAL_RECOVERY_EN
    step();
    check("rec_state", 32'(s5), 0);
    check("rec_err", 32'(err5), 1);
    step();
    check("rec_state_next", 32'(s5), 1);
    check("rec_err_clear", 32'(err5), 0);
`else
    step();
    check("ill_hold_a", 32'(s5), 6);
    check("ill_err", 32'(err5), 0);
    check("ill_y_hold", 32'(y5), 0);
    step();
    check("ill_hold_b", 32'(s5), 6);
    check("ill_oh_hold", 32'(oh5), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
